bram_sd_writer: RTL
===================

BRAM_SD_WRITER -- requirements
Module: bram_sd_writer

Interface
REQ-001 Parameters SHALL be:
- TOTAL_PIXELS, default 307200, number of 640x480 bin entries to dump.
- BYTES_PER_BLOCK, default 512, SD block size.
- BRAM_LATENCY, default 2, cycles from bram_addr to valid bin_data.
REQ-002 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, shared with the SD controller (25 MHz).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a dump.
- base_addr  in  32  SD byte address of the first block; must be 512-aligned.
- bram_addr  out  19  xy_bin read address.
- bin_data  in  3  xy_bin read data.
- sd_ready  in  1  controller idle, able to accept a command.
- sd_wr  out  1  block-write request.
- sd_addr  out  32  block address presented with sd_wr.
- sd_din  out  8  byte to be written.
- sd_ready_for_next_byte  in  1  controller consumed sd_din and wants the next byte.
- busy  out  1  dump in progress.
- done  out  1  dump complete.
- block_count  out  10  blocks fully written in the current dump.

Function
REQ-004 Each pixel SHALL be written as one byte {5'b0, bin}; the dump spans TOTAL_PIXELS/BYTES_PER_BLOCK = 600 blocks.
REQ-005 The state machine SHALL have states IDLE, WAIT_READY, ISSUE, PREFETCH, STREAM, BLOCK_END and FINISHED.
REQ-006 IDLE -> WAIT_READY when start=1; this transition SHALL latch base_addr and clear bram_addr, block_count and done.
REQ-007 start SHALL be ignored in every state except IDLE and FINISHED.
REQ-008 WAIT_READY -> PREFETCH when sd_ready=1.
REQ-009 PREFETCH SHALL load sd_din with the byte at bram_addr exactly BRAM_LATENCY cycles after entry, then go to ISSUE.
REQ-010 ISSUE SHALL:
- drive sd_wr=1 and sd_addr = base_addr + block_count*512;
- hold both until sd_ready=0;
- then go to STREAM.
REQ-011 STREAM SHALL detect each rising edge of sd_ready_for_next_byte; a level held across several cycles counts once.
REQ-012 On each rising edge, STREAM SHALL increment bram_addr and reload sd_din with the new byte within BRAM_LATENCY+1 cycles.
REQ-013 sd_din SHALL remain stable between reloads.
REQ-014 After the 512th rising edge of a block, STREAM SHALL stop fetching and go to BLOCK_END; the byte counter is 9 bits and wraps 511 -> 0.
REQ-015 BLOCK_END SHALL wait for sd_ready=1, then increment block_count.
REQ-016 From BLOCK_END, the next state SHALL be:
- FINISHED if block_count has reached 600;
- otherwise PREFETCH, with bram_addr already pointing at the next block's first pixel.
REQ-017 bram_addr SHALL never exceed TOTAL_PIXELS-1; the final increment is suppressed.
REQ-018 busy SHALL be 1 in every state except IDLE and FINISHED.
REQ-019 done SHALL be 1 only in FINISHED, held until start or reset.
REQ-020 FINISHED -> WAIT_READY on start, with the same latching as REQ-006.
REQ-021 sd_ready_for_next_byte edges received outside STREAM SHALL be ignored.

Reset
REQ-022 On reset the block SHALL enter IDLE with sd_wr=0, sd_addr=0, sd_din=0, bram_addr=0, block_count=0, busy=0, done=0.
REQ-023 Reset asserted mid-block SHALL deassert sd_wr in the same cycle and abandon the dump; there is no resume.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Ramp dump: BRAM[i]=i%8, base_addr=0x0001_0000, start, behavioural controller model -> 600 sd_wr commands at 0x10000 + k*512; 307200 bytes captured, byte i = i%8; done=1; block_count=600.
- Handshake: ready_for_next_byte high for 3 cycles per byte, 16 cycles apart -> exactly 512 bytes per block; no skipped or duplicated pixel; sd_din stable while the pulse is high.
- Delayed acceptance: sd_ready stays 1 for 20 cycles after sd_wr -> sd_wr and sd_addr held for all 20 cycles; no byte advance.
- Busy start: start pulsed while busy=1 -> ignored; block_count and sd_addr sequence unchanged.
- Reset mid-dump: reset during byte 200 of block 5 -> next cycle sd_wr=0, busy=0, bram_addr=0; a later start restarts at base_addr.
- Restart from FINISHED: start with base_addr=0x0040_0000 -> done clears; the first sd_addr is 0x0040_0000.

Source files
------------

// File: rtl/bram_sd_writer.sv
// -----------------------------------------------------------------------------
// bram_sd_writer
//
// Dumps the xy_bin BRAM (one 3-bit bin per pixel) to an SD card as raw
// 512-byte blocks. Each pixel becomes one byte {5'b0, bin}. The block talks to
// a byte-streaming SD controller: it raises sd_wr with a block address, then
// feeds one byte per rising edge of sd_ready_for_next_byte.
//
// Ports
//   clk                     in   single clock shared with the SD controller
//   reset                   in   synchronous, active-high
//   start                   in   one-cycle dump request (IDLE/FINISHED only)
//   base_addr[31:0]         in   SD byte address of the first block (512-aligned)
//   bram_addr[18:0]         out  xy_bin read address
//   bin_data[2:0]           in   xy_bin read data, BRAM_LATENCY cycles after addr
//   sd_ready                in   controller idle / able to accept a command
//   sd_wr                   out  block-write request
//   sd_addr[31:0]           out  block address presented with sd_wr
//   sd_din[7:0]             out  byte being offered to the controller
//   sd_ready_for_next_byte  in   controller consumed sd_din, wants the next one
//   busy                    out  dump in progress
//   done                    out  dump complete (held until start or reset)
//   block_count[9:0]        out  blocks fully written in the current dump
// -----------------------------------------------------------------------------
module bram_sd_writer #(
    parameter int TOTAL_PIXELS    = 307200,
    parameter int BYTES_PER_BLOCK = 512,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic [18:0] bram_addr,
    input  logic [2:0]  bin_data,
    input  logic        sd_ready,
    output logic        sd_wr,
    output logic [31:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte,
    output logic        busy,
    output logic        done,
    output logic [9:0]  block_count
);

    localparam int NUM_BLOCKS = TOTAL_PIXELS / BYTES_PER_BLOCK;
    localparam int BYTE_W     = $clog2(BYTES_PER_BLOCK);
    localparam int LAT_W      = $clog2(BRAM_LATENCY + 1);

    localparam logic [18:0]       LAST_ADDR  = 19'(TOTAL_PIXELS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(BYTES_PER_BLOCK - 1);
    localparam logic [9:0]        LAST_BLOCK = 10'(NUM_BLOCKS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(BRAM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ISSUE,
        S_PREFETCH,
        S_STREAM,
        S_BLOCK_END,
        S_FINISHED
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [31:0]         r_base_addr;
    logic [18:0]         r_bram_addr;
    logic [9:0]          r_block_count;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic [7:0]          r_sd_din;
    logic                r_rfnb_q;
    logic [LAT_W-1:0]    r_lat_cnt;
    // One bit per outstanding BRAM read; the top bit marks the cycle the
    // requested byte is valid on bin_data.
    logic [BRAM_LATENCY:0] r_load_pipe;

    logic w_start_ok;
    logic w_rfnb_rise;
    logic w_last_byte;
    logic w_prefetch_done;
    logic w_block_done;

    // start only matters when no dump is running.
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_FINISHED));

    // A byte request is the 0->1 transition of the handshake, and only while
    // streaming; a level held high or an edge outside STREAM is ignored.
    assign w_rfnb_rise = (r_state == S_STREAM) && sd_ready_for_next_byte && !r_rfnb_q;

    // The last request of a block: that byte is already on sd_din, so no new
    // fetch is launched for it.
    assign w_last_byte = w_rfnb_rise && (r_byte_cnt == LAST_BYTE);

    // bram_addr is settled before PREFETCH is entered, so after BRAM_LATENCY
    // cycles bin_data holds the block's first byte.
    assign w_prefetch_done = (r_state == S_PREFETCH) && (r_lat_cnt == LAT_LAST);

    assign w_block_done = (r_state == S_BLOCK_END) && sd_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin : next_state_logic
        // NOTE: default assignment first, so no path through the case leaves
        // w_next_state unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_FINISHED: begin
                if (start) w_next_state = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (sd_ready) w_next_state = S_PREFETCH;
            end
            S_PREFETCH: begin
                if (w_prefetch_done) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                // The controller drops sd_ready once it has taken the command.
                if (!sd_ready) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_byte) w_next_state = S_BLOCK_END;
            end
            S_BLOCK_END: begin
                if (sd_ready) begin
                    w_next_state = (r_block_count == LAST_BLOCK) ? S_FINISHED : S_PREFETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin : fsm_outputs
        sd_wr = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (r_state)
            S_IDLE:     busy  = 1'b0;
            S_FINISHED: begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_ISSUE:    sd_wr = 1'b1;
            default:    ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: addresses, counters and the byte register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : datapath
        if (reset) begin
            r_base_addr   <= '0;
            r_bram_addr   <= '0;
            r_block_count <= '0;
            r_byte_cnt    <= '0;
            r_sd_din      <= '0;
            r_rfnb_q      <= 1'b0;
            r_lat_cnt     <= '0;
            r_load_pipe   <= '0;
        end else begin
            r_rfnb_q    <= sd_ready_for_next_byte;
            r_load_pipe <= {r_load_pipe[BRAM_LATENCY-1:0], w_rfnb_rise && !w_last_byte};
            r_lat_cnt   <= (r_state == S_PREFETCH) ? r_lat_cnt + LAT_W'(1) : '0;

            if (w_start_ok) begin
                r_base_addr   <= base_addr;
                r_bram_addr   <= '0;
                r_block_count <= '0;
                r_byte_cnt    <= '0;
            end

            if (w_rfnb_rise) begin
                // Wraps back to 0 on the last byte, ready for the next block.
                r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                // The final pixel has no successor; hold the address there.
                if (r_bram_addr != LAST_ADDR) begin
                    r_bram_addr <= r_bram_addr + 19'd1;
                end
            end

            // sd_din only changes on these two events, so it is stable while
            // the controller is reading it.
            if (w_prefetch_done || r_load_pipe[BRAM_LATENCY]) begin
                r_sd_din <= {5'b0, bin_data};
            end

            if (w_block_done) begin
                r_block_count <= r_block_count + 10'd1;
            end
        end
    end

    assign bram_addr   = r_bram_addr;
    assign sd_din      = r_sd_din;
    assign block_count = r_block_count;
    assign sd_addr     = r_base_addr + (32'(r_block_count) * 32'(BYTES_PER_BLOCK));

endmodule
